// File: rtl/ddc_quad_mixer_decim.sv
// Quadrature mixer (I = x*cos, Q = -x*sin) followed by integrate-and-dump decimation.
// Latency: 3 clk from an accepted input sample to the out_valid strobe of the block it closes.
// No backpressure: accepts one sample per cycle when in_valid is high; outputs are a strobe.
module ddc_quad_mixer_decim #(
    parameter int ADC_W     = 10,
    parameter int LO_W      = 10,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADC_W-1:0]        adc_data,
    input  logic [LO_W-1:0]         lo_sin,
    input  logic [LO_W-1:0]         lo_cos,
    input  logic                    in_valid,
    input  logic                    clr,
    input  logic [7:0]              dec_len,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    out_valid,
    output logic                    sat
);

    localparam int P = ADC_W + LO_W;
    localparam int A = P + 8;
    localparam logic signed [A-1:0] OMAX = A'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [A-1:0] OMIN = ~OMAX;

    // Stage 1: signed ADC sample, LO samples and the block length travelling with the sample
    logic signed [ADC_W-1:0] x_q, x_d;
    logic signed [LO_W-1:0]  sin1_q, sin1_d, cos1_q, cos1_d;
    logic [7:0]              len1_q, len1_d;
    logic                    v1_q, v1_d;
    // Stage 2: full-precision products
    logic signed [P-1:0]     p_i_q, p_i_d, p_q_q, p_q_d;
    logic [7:0]              len2_q, len2_d;
    logic                    v2_q, v2_d;
    // Stage 3: accumulators, sample counter, block length and outputs
    logic signed [A-1:0]     acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [7:0]              cnt_q, cnt_d, len_reg_q, len_reg_d;
    logic signed [OUT_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
    logic                    out_valid_q, out_valid_d, sat_q, sat_d;

    // Scale a block sum down and clip it; MSB of the result flags clipping.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [A-1:0] v);
        logic signed [A-1:0] s;
        s = v >>> OUT_SHIFT;
        if (s > OMAX)      return {1'b1, OMAX[OUT_W-1:0]};
        else if (s < OMIN) return {1'b1, OMIN[OUT_W-1:0]};
        else               return {1'b0, s[OUT_W-1:0]};
    endfunction

    // Stage 1: offset-binary to two's complement (MSB flip); data regs load only on valid
    always_comb begin
        x_d    = x_q;
        sin1_d = sin1_q;
        cos1_d = cos1_q;
        len1_d = len1_q;
        v1_d   = in_valid & ~clr;
        if (in_valid) begin
            x_d    = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
            sin1_d = lo_sin;
            cos1_d = lo_cos;
            len1_d = dec_len;
        end
    end

    // Stage 2: sign-extend to product width so (-2^(N-1))^2 cannot overflow
    logic signed [P-1:0] x_ext, sin_ext, cos_ext, prod_s;
    always_comb begin
        x_ext   = {{LO_W{x_q[ADC_W-1]}}, x_q};
        sin_ext = {{ADC_W{sin1_q[LO_W-1]}}, sin1_q};
        cos_ext = {{ADC_W{cos1_q[LO_W-1]}}, cos1_q};
        prod_s  = '0;
        p_i_d   = p_i_q;
        p_q_d   = p_q_q;
        len2_d  = len2_q;
        v2_d    = v1_q & ~clr;
        if (v1_q) begin
            p_i_d  = x_ext * cos_ext;
            prod_s = x_ext * sin_ext;
            p_q_d  = -prod_s;
            len2_d = len1_q;
        end
    end

    // Stage 3: integrate, dump on the last sample of a block; block length is fixed by its first sample
    logic signed [A-1:0] sum_i, sum_q;
    logic [7:0]          cur_len, eff_len;
    logic                last;
    logic [OUT_W:0]      ri, rq;
    always_comb begin
        sum_i       = acc_i_q + {{8{p_i_q[P-1]}}, p_i_q};
        sum_q       = acc_q_q + {{8{p_q_q[P-1]}}, p_q_q};
        cur_len     = (cnt_q == 8'd0) ? len2_q : len_reg_q;
        eff_len     = (cur_len == 8'd0) ? 8'd1 : cur_len;
        last        = (cnt_q == eff_len - 8'd1);
        ri          = sat_fn(sum_i);
        rq          = sat_fn(sum_q);
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        cnt_d       = cnt_q;
        len_reg_d   = len_reg_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        if (clr) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = 8'd0;
        end else if (v2_q) begin
            if (cnt_q == 8'd0) len_reg_d = eff_len;
            if (last) begin
                i_out_d     = ri[OUT_W-1:0];
                q_out_d     = rq[OUT_W-1:0];
                sat_d       = ri[OUT_W] | rq[OUT_W];
                out_valid_d = 1'b1;
                acc_i_d     = '0;
                acc_q_d     = '0;
                cnt_d       = 8'd0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_q + 8'd1;
            end
        end
    end

    // State registers for all three stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            sin1_q      <= '0;
            cos1_q      <= '0;
            len1_q      <= '0;
            v1_q        <= 1'b0;
            p_i_q       <= '0;
            p_q_q       <= '0;
            len2_q      <= '0;
            v2_q        <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            len_reg_q   <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            sin1_q      <= sin1_d;
            cos1_q      <= cos1_d;
            len1_q      <= len1_d;
            v1_q        <= v1_d;
            p_i_q       <= p_i_d;
            p_q_q       <= p_q_d;
            len2_q      <= len2_d;
            v2_q        <= v2_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
            len_reg_q   <= len_reg_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;

endmodule
